id_stage: RTL and testbench

Decode stage of the RISC-V core, directly downstream of instruction fetch. Selects the BIOS or IMEM synchronous-read output using the PC register handed over by fetch. Holds the instruction across stalls and squashes wrong-path instructions after redirects. Detects load-use hazards, generates register-file read addresses and immediates, and drives the ID/EX pipeline registers.

---
 rtl/id_stage.sv | 170 +++++++++++++++++
 tb/tb_id_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage. Picks BIOS or IMEM read data by the fetch PC,
// replays the instruction held across a load-use stall, squashes wrong-path
// instructions after a redirect, decodes register addresses and immediates,
// and drives the ID/EX pipeline register.
//
// Handshake: there is no valid/ready pair. id_stall is a one-cycle hold
// request to fetch (PC and fetch registers freeze while it is high); flush
// always overrides it, and ex_valid marks whether the EX slot carries a real
// instruction or a bubble.
module id_stage #(
   parameter logic [31:0] NOP      = 32'h0000_0013,
   parameter int          BIOS_BIT = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] id_pc,
   input  logic [31:0] bios_dout,
   input  logic [31:0] imem_dout,
   input  logic        flush,
   output logic        id_stall,
   output logic [4:0]  id_rs1,
   output logic [4:0]  id_rs2,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_inst,
   output logic [31:0] ex_imm,
   output logic [4:0]  ex_rd,
   output logic        ex_valid
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic        hold_valid;
   logic [31:0] hold_inst;
   logic        kill_next;

   logic [31:0] raw_inst;
   logic [31:0] id_inst;
   logic [31:0] id_imm;
   logic [4:0]  id_rd;
   logic [6:0]  opcode;
   logic        id_valid;
   logic        hazard;

   // Select the memory that owns the presented PC.
   always_comb begin
      raw_inst = id_pc[BIOS_BIT] ? bios_dout : imem_dout;
   end

   // Effective ID instruction. flush is deliberately left out here so the
   // register-file addresses never depend combinationally on the redirect;
   // a flushed instruction is discarded at the ID/EX register instead.
   always_comb begin
      if (kill_next) begin
         id_inst = NOP;
      end else if (hold_valid) begin
         id_inst = hold_inst;
      end else begin
         id_inst = raw_inst;
      end
      id_valid = !kill_next && !flush;
   end

   // Register addresses, destination and immediate decode.
   always_comb begin
      opcode = id_inst[6:0];
      id_rs1 = id_inst[19:15];
      id_rs2 = 5'd0;
      id_rd  = id_inst[11:7];
      id_imm = 32'd0;
      case (opcode)
         OP_LUI, OP_AUIPC: begin
            id_rs1 = 5'd0;
            id_imm = {id_inst[31:12], 12'd0};
         end
         OP_JAL: begin
            id_rs1 = 5'd0;
            id_imm = {{11{id_inst[31]}}, id_inst[31], id_inst[19:12],
                      id_inst[20], id_inst[30:21], 1'b0};
         end
         OP_SYSTEM: begin
            // CSR immediate forms carry a zimm in the rs1 field.
            if (id_inst[14]) id_rs1 = 5'd0;
            id_imm = {{20{id_inst[31]}}, id_inst[31:20]};
         end
         OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: begin
            id_imm = {{20{id_inst[31]}}, id_inst[31:20]};
         end
         OP_STORE: begin
            id_rs2 = id_inst[24:20];
            id_rd  = 5'd0;
            id_imm = {{20{id_inst[31]}}, id_inst[31:25], id_inst[11:7]};
         end
         OP_BRANCH: begin
            id_rs2 = id_inst[24:20];
            id_rd  = 5'd0;
            id_imm = {{19{id_inst[31]}}, id_inst[31], id_inst[7],
                      id_inst[30:25], id_inst[11:8], 1'b0};
         end
         OP_REG: begin
            id_rs2 = id_inst[24:20];
         end
         default: begin
            id_imm = 32'd0;
         end
      endcase
   end

   // Load-use hazard against the instruction currently in EX.
   always_comb begin
      hazard = ex_valid && (ex_inst[6:0] == OP_LOAD) && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2)) && id_valid;
      id_stall = hazard && !flush;
   end

   // Squash marker: the cycle after a flush (and after reset) is wrong-path.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kill_next <= 1'b1;
      end else begin
         kill_next <= flush;
      end
   end

   // Capture the memory word on the first stall cycle; fetch has already
   // moved the memory on, so the stalled instruction must be replayed from here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_valid <= 1'b0;
         hold_inst  <= NOP;
      end else if (flush || !id_stall) begin
         hold_valid <= 1'b0;
      end else if (!hold_valid) begin
         hold_valid <= 1'b1;
         hold_inst  <= raw_inst;
      end
   end

   // ID/EX pipeline register: flush and stall both insert a bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_pc    <= 32'd0;
         ex_inst  <= NOP;
         ex_imm   <= 32'd0;
         ex_rd    <= 5'd0;
         ex_valid <= 1'b0;
      end else if (flush || id_stall) begin
         ex_inst  <= NOP;
         ex_imm   <= 32'd0;
         ex_rd    <= 5'd0;
         ex_valid <= 1'b0;
      end else begin
         ex_pc    <= id_pc;
         ex_inst  <= id_inst;
         ex_imm   <= id_imm;
         ex_rd    <= id_rd;
         ex_valid <= id_valid;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed test-plan sequences with literal expectations, then
// randomized instruction streams, all checked against an instruction-level
// model of the decode stage.
module tb_id_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam logic [31:0] I_ADDI1_5 = 32'h0050_0093; // addi x1,x0,5
   localparam logic [31:0] I_LW5     = 32'h0000_A283; // lw x5,0(x1)
   localparam logic [31:0] I_ADD6    = 32'h0022_8333; // add x6,x5,x2
   localparam logic [31:0] I_ADDI7   = 32'h0010_0393; // addi x7,x0,1
   localparam logic [31:0] I_LUI5    = 32'h0002_82B7; // lui x5,0x28
   localparam logic [31:0] I_LW0     = 32'h0000_A003; // lw x0,0(x1)
   localparam logic [31:0] I_ADD_X0  = 32'h0020_0333; // add x6,x0,x2
   localparam logic [31:0] I_ADDI3   = 32'h0070_0193; // addi x3,x0,7
   localparam logic [31:0] I_SW      = 32'hFE20_AE23; // sw x2,-4(x1)
   localparam logic [31:0] I_BEQ     = 32'h0020_80E3; // beq x1,x2,+0x800
   localparam logic [31:0] I_JAL     = 32'hFFFF_F0EF; // jal x1,-2

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] id_pc = 32'd0;
   logic [31:0] bios_dout = NOP;
   logic [31:0] imem_dout = NOP;
   logic        flush = 1'b0;
   logic        id_stall;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [31:0] ex_pc;
   logic [31:0] ex_inst;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rd;
   logic        ex_valid;

   id_stage dut (
      .clk(clk), .rst(rst), .id_pc(id_pc), .bios_dout(bios_dout),
      .imem_dout(imem_dout), .flush(flush), .id_stall(id_stall),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_pc(ex_pc), .ex_inst(ex_inst),
      .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_valid(ex_valid)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int n_checks = 0;
   int n_pass   = 0;

   // Instruction-level model state
   logic        m_kill;
   logic        m_replay_v;
   logic [31:0] m_replay_i;
   logic [31:0] m_cur;
   logic        m_idv;
   logic        m_stall;
   logic [4:0]  m_rs1, m_rs2;
   logic [31:0] m_ex_pc, m_ex_inst, m_ex_imm;
   logic [4:0]  m_ex_rd;
   logic        m_ex_valid;
   logic [31:0] exp_q[$];
   logic        last_stall;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [4:0] f_rs1(input logic [31:0] i);
      if (i[6:0] inside {7'h37, 7'h17, 7'h6F}) return 5'd0;
      if (i[6:0] == 7'h73 && i[14]) return 5'd0;
      return i[19:15];
   endfunction

   function automatic logic [4:0] f_rs2(input logic [31:0] i);
      return (i[6:0] inside {7'h33, 7'h23, 7'h63}) ? i[24:20] : 5'd0;
   endfunction

   function automatic logic [4:0] f_rd(input logic [31:0] i);
      return (i[6:0] inside {7'h23, 7'h63}) ? 5'd0 : i[11:7];
   endfunction

   // Immediates rebuilt with arithmetic shifts of the whole word.
   function automatic logic [31:0] f_imm(input logic [31:0] i);
      logic signed [31:0] s;
      case (i[6:0])
         7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: begin
            s = $signed(i) >>> 20;
            return s;
         end
         7'h23: begin
            s = $signed(i) >>> 20;
            return (s & ~32'd31) | 32'(i[11:7]);
         end
         7'h63: begin
            s = $signed(i) >>> 19;
            return (s & 32'hFFFF_F000) | (32'(i[7]) << 11) |
                   (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
         end
         7'h37, 7'h17: return i & 32'hFFFF_F000;
         7'h6F: begin
            s = $signed(i) >>> 11;
            return (s & 32'hFFF0_0000) | (32'(i[19:12]) << 12) |
                   (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
         end
         default: return 32'd0;
      endcase
   endfunction

   function automatic void model_reset();
      m_kill     = 1'b1;
      m_replay_v = 1'b0;
      m_replay_i = NOP;
      m_ex_pc    = 32'd0;
      m_ex_inst  = NOP;
      m_ex_imm   = 32'd0;
      m_ex_rd    = 5'd0;
      m_ex_valid = 1'b0;
      exp_q.delete();
   endfunction

   // What ID sees this cycle, and whether it must wait for a load in EX.
   function automatic void model_eval();
      logic [31:0] fetched;
      fetched = id_pc[30] ? bios_dout : imem_dout;
      m_cur   = m_kill ? NOP : (m_replay_v ? m_replay_i : fetched);
      m_rs1   = f_rs1(m_cur);
      m_rs2   = f_rs2(m_cur);
      m_idv   = !m_kill && !flush;
      m_stall = m_idv && m_ex_valid && (m_ex_inst[6:0] == 7'h03) && (m_ex_rd != 5'd0) &&
                ((m_ex_rd == m_rs1) || (m_ex_rd == m_rs2));
   endfunction

   // Advance one clock: a stalled instruction is replayed next cycle.
   function automatic void model_clock();
      if (flush || m_stall) begin
         m_ex_inst  = NOP;
         m_ex_imm   = 32'd0;
         m_ex_rd    = 5'd0;
         m_ex_valid = 1'b0;
      end else begin
         m_ex_pc    = id_pc;
         m_ex_inst  = m_cur;
         m_ex_imm   = f_imm(m_cur);
         m_ex_rd    = f_rd(m_cur);
         m_ex_valid = m_idv;
      end
      m_replay_v = m_stall;
      m_replay_i = m_cur;
      m_kill     = flush;
      exp_q.push_back(m_ex_inst);
   endfunction

   // Driver + compare for one clock; entered and left at a falling edge.
   task automatic cycle(input logic [31:0] pc, input logic [31:0] bios,
                        input logic [31:0] imem, input logic fl);
      logic [31:0] exp_inst;
      id_pc     = pc;
      bios_dout = bios;
      imem_dout = imem;
      flush     = fl;
      #1;
      model_eval();
      last_stall = id_stall;
      check("id_stall", 32'(id_stall), 32'(m_stall));
      check("id_rs1", 32'(id_rs1), 32'(m_rs1));
      check("id_rs2", 32'(id_rs2), 32'(m_rs2));
      model_clock();
      @(posedge clk);
      #1;
      exp_inst = exp_q.pop_front();
      check("ex_inst", ex_inst, exp_inst);
      check("ex_valid", 32'(ex_valid), 32'(m_ex_valid));
      check("ex_pc", ex_pc, m_ex_pc);
      check("ex_imm", ex_imm, m_ex_imm);
      check("ex_rd", 32'(ex_rd), 32'(m_ex_rd));
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
      check({tag, "_ex_inst"}, ex_inst, NOP);
      check({tag, "_ex_pc"}, ex_pc, 32'd0);
      check({tag, "_ex_imm"}, ex_imm, 32'd0);
      check({tag, "_ex_rd"}, 32'(ex_rd), 32'd0);
      check({tag, "_id_stall"}, 32'(id_stall), 32'd0);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 11))
         0, 1:    w[6:0] = 7'h03;
         2, 3:    w[6:0] = 7'h33;
         4:       w[6:0] = 7'h13;
         5:       w[6:0] = 7'h23;
         6:       w[6:0] = 7'h63;
         7:       w[6:0] = 7'h37;
         8:       w[6:0] = 7'h17;
         9:       w[6:0] = 7'h6F;
         10:      w[6:0] = 7'h73;
         default: w[6:0] = 7'h67;
      endcase
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      return w;
   endfunction

   initial begin
      logic [31:0] pc;
      logic        fl;

      // Reset state
      model_reset();
      id_pc     = 32'h4000_0000;
      bios_dout = I_ADDI1_5;
      imem_dout = 32'hDEAD_BEEF;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      rst = 1'b1;

      // First instruction after reset, from BIOS
      cycle(32'h4000_0000, I_ADDI1_5, 32'hDEAD_BEEF, 1'b0);
      check("boot_c1_valid", 32'(ex_valid), 32'd0);
      cycle(32'h4000_0000, I_ADDI1_5, 32'hDEAD_BEEF, 1'b0);
      check("boot_c2_valid", 32'(ex_valid), 32'd1);
      check("boot_c2_inst", ex_inst, I_ADDI1_5);
      check("boot_c2_rd", 32'(ex_rd), 32'd1);
      check("boot_c2_imm", ex_imm, 32'd5);
      check("boot_c2_pc", ex_pc, 32'h4000_0000);

      // Load-use: one stall, add replayed from hold
      cycle(32'h0000_1000, 32'd0, I_LW5, 1'b0);
      cycle(32'h0000_1004, 32'd0, I_ADD6, 1'b0);
      check("lu_stall", 32'(last_stall), 32'd1);
      check("lu_bubble", 32'(ex_valid), 32'd0);
      cycle(32'h0000_1004, 32'd0, I_ADDI7, 1'b0);
      check("lu_nostall2", 32'(last_stall), 32'd0);
      check("lu_add_inst", ex_inst, I_ADD6);
      check("lu_add_pc", ex_pc, 32'h0000_1004);
      check("lu_add_rd", 32'(ex_rd), 32'd6);

      // No stall: lw x5 then lui x5; lw x0 then use of x0
      cycle(32'h0000_1008, 32'd0, I_LW5, 1'b0);
      cycle(32'h0000_100C, 32'd0, I_LUI5, 1'b0);
      check("lui_nostall", 32'(last_stall), 32'd0);
      check("lui_issued", ex_inst, I_LUI5);
      cycle(32'h0000_1010, 32'd0, I_LW0, 1'b0);
      cycle(32'h0000_1014, 32'd0, I_ADD_X0, 1'b0);
      check("x0_nostall", 32'(last_stall), 32'd0);
      check("x0_issued", 32'(ex_valid), 32'd1);

      // Flush with a valid ID instruction; target from IMEM (pc[30]=0)
      cycle(32'h0000_1018, 32'd0, I_ADDI7, 1'b1);
      check("fl_bubble1", 32'(ex_valid), 32'd0);
      cycle(32'h0000_101C, 32'd0, I_ADDI3, 1'b0);
      check("fl_bubble2", 32'(ex_valid), 32'd0);
      cycle(32'h0000_3000, 32'hFFFF_FFFF, I_ADDI3, 1'b0);
      check("fl_target_valid", 32'(ex_valid), 32'd1);
      check("imem_select", ex_inst, I_ADDI3);
      check("fl_target_pc", ex_pc, 32'h0000_3000);

      // Flush in the same cycle as a load-use hazard
      cycle(32'h0000_3004, 32'd0, I_LW5, 1'b0);
      cycle(32'h0000_3008, 32'd0, I_ADD6, 1'b1);
      check("flhz_nostall", 32'(last_stall), 32'd0);
      check("flhz_bubble1", 32'(ex_valid), 32'd0);
      cycle(32'h0000_300C, 32'd0, I_ADDI3, 1'b0);
      check("flhz_bubble2", 32'(ex_valid), 32'd0);
      cycle(32'h0000_5000, 32'd0, I_ADDI7, 1'b0);
      check("flhz_hold_clear", ex_inst, I_ADDI7);

      // Immediates
      cycle(32'h0000_5004, 32'd0, I_SW, 1'b0);
      check("sw_imm", ex_imm, 32'hFFFF_FFFC);
      check("sw_rd", 32'(ex_rd), 32'd0);
      cycle(32'h0000_5008, 32'd0, I_BEQ, 1'b0);
      check("beq_imm", ex_imm, 32'h0000_0800);
      cycle(32'h0000_500C, 32'd0, I_JAL, 1'b0);
      check("jal_imm", ex_imm, 32'hFFFF_FFFE);
      check("jal_rd", 32'(ex_rd), 32'd1);

      // Reset asserted in the middle of a stall
      cycle(32'h0000_6000, 32'd0, I_LW5, 1'b0);
      id_pc     = 32'h0000_6004;
      imem_dout = I_ADD6;
      flush     = 1'b0;
      #1;
      check("mid_stall_req", 32'(id_stall), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      cycle(32'h0000_6004, 32'd0, I_ADDI3, 1'b0);
      cycle(32'h0000_6004, 32'd0, I_ADDI3, 1'b0);
      check("post_rst_inst", ex_inst, I_ADDI3);

      // Randomized instruction streams with redirects
      pc = 32'h0000_8000;
      for (int c = 0; c < 3000; c++) begin
         fl = ($urandom_range(0, 9) == 0);
         cycle(pc, rand_inst(), rand_inst(), fl);
         if (fl) pc = {1'b0, 1'($urandom_range(0, 1)), 28'($urandom), 2'b00};
         else if (!m_stall) pc = pc + 32'd4;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
